load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have req_i (in, 1): request strobe, sampled only while ready_o=1.
REQ-004 SHALL have we_i (in, 1): 1 = store, 0 = load.
REQ-005 SHALL have size_i (in, 2): 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
REQ-006 SHALL have unsigned_i (in, 1): 1 = zero-extend loads, 0 = sign-extend loads.
REQ-007 SHALL have addr_i (in, 32), the byte address, and wdata_i (in, 32), the store data, right-aligned.
REQ-008 SHALL have ready_o (out, 1), done_o (out, 1, one-cycle pulse), rdata_o (out, 32) and misalign_o (out, 1, qualified by done_o).
REQ-009 SHALL have mem_addr_o (out, 32) and mem_data_o (out, 32), the word-aligned memory address and the write word.
REQ-010 SHALL have mem_read_o (out, 1), mem_write_o (out, 1) and mem_data_i (in, 32).
- mem_data_i is the combinational little-endian read word: byte at mem_addr_o is mem_data_i[7:0].
- Memory writes all 4 bytes on the clock edge where mem_write_o=1.

Function
REQ-011 SHALL implement states IDLE, RD, WR, DONE; ready_o=1 only in IDLE.
REQ-012 SHALL, on req_i=1 in IDLE, latch we_i, size_i, unsigned_i, addr_i and wdata_i; inputs after acceptance SHALL NOT affect the operation.
REQ-013 Transitions SHALL be:
- Load: IDLE->RD->DONE.
- Word store: IDLE->WR->DONE.
- Byte or halfword store: IDLE->RD->WR->DONE (read-modify-write).
- DONE->IDLE always.
REQ-014 SHALL drive mem_addr_o = {latched addr[31:2], 2'b00} in RD and WR, and 0 in IDLE and DONE.
REQ-015 SHALL assert mem_read_o only in RD, and mem_write_o only in WR.
REQ-016 SHALL capture mem_data_i into an internal word register at the end of RD.
REQ-017 SHALL form the store word as follows:
- Word: wdata.
- Byte: captured word with lane addr[1:0] (bits 8*lane+7:8*lane) replaced by wdata[7:0].
- Halfword: captured word with lane addr[1] (bits 16*lane+15:16*lane) replaced by wdata[15:0].
- mem_data_o SHALL be 0 outside WR.
REQ-018 SHALL, for loads, extract the selected lane and extend it to 32 bits per unsigned_i, updating rdata_o on entry to DONE; rdata_o holds until the next completed load.
REQ-019 SHALL pulse done_o for exactly the DONE cycle; latency from acceptance edge is 2 cycles for loads and word stores, 3 for sub-word stores.
REQ-020 SHALL ignore req_i while ready_o=0; a req_i held high through DONE is accepted in the following IDLE cycle.

Reset
REQ-021 SHALL, while rst_i=0, force state IDLE and asynchronously clear all outputs and registers to 0, except ready_o=1.
REQ-022 SHALL abort any in-flight operation on reset with no further memory write; mem_write_o SHALL fall immediately with rst_i.

Configuration
REQ-023 With LSU_MISALIGN_TRAP_EN defined, halfword requests with addr[0]=1 and word requests with addr[1:0]!=0 SHALL go IDLE->DONE with no memory access, misalign_o=1 with done_o, and rdata_o unchanged.
REQ-024 Without LSU_MISALIGN_TRAP_EN, misaligned low address bits SHALL be ignored (halfword uses addr[1], word uses the aligned word) and misalign_o SHALL be tied 0.

Verification
REQ-025 Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem write word 0xDEADBEEF @0x10; load done 2 cycles after acceptance with rdata_o=0xDEADBEEF.
REQ-026 Word 0x11223344 @0x20, byte store 0xAA @0x22 -> memory word 0x11AA3344; signed byte load @0x22 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-027 Halfword store 0x8001 @0x26 onto word 0 -> word 0x80010000; signed halfword load @0x26 -> 0xFFFF8001; done 3 cycles after acceptance for the store.
REQ-028 rst_i pulled low during WR of a byte store -> mem_write_o falls immediately, memory word unchanged, ready_o=1 after release.
REQ-029 With LSU_MISALIGN_TRAP_EN, word load @0x13 -> done_o and misalign_o 1 cycle after acceptance, mem_read_o never asserted; without the macro, the same request reads 0x10.
REQ-030 req_i held high continuously with alternating loads and stores -> each accepted only in IDLE, with no dropped or duplicated done_o pulses.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores to a 32-bit word memory.
// Ports: clk_i, rst_i (async active-low); request side req_i, we_i, size_i,
//   unsigned_i, addr_i, wdata_i -> ready_o, done_o, rdata_o, misalign_o;
//   memory side mem_addr_o, mem_data_o, mem_read_o, mem_write_o <- mem_data_i.
// Option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word requests.
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        accept;
    logic        mis_req;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;
    logic [31:0] st_word;

    assign accept = (state_q == IDLE) && req_i;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign mis_req = (size_i == 2'b01 && addr_i[0]) ||
                     (size_i[1] && addr_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= mis_req;
        end
    end

    assign misalign_o = done_o & mis_q;
`else
    assign mis_req    = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: sub-word stores take the extra RD for read-modify-write
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (mis_req) begin
                        state_d = DONE;
                    end else if (we_i && size_i[1]) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:   state_d = we_q ? WR : DONE;
            WR:   state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    // Request latch, read capture and load result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_o <= '0;
        end else begin
            if (accept) begin
                we_q    <= we_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (state_q == RD) begin
                word_q <= mem_data_i;
                if (!we_q) begin
                    rdata_o <= ld_ext;
                end
            end
        end
    end

    // Load lane select and extension
    always_comb begin
        ld_b   = mem_data_i[{addr_q[1:0], 3'b000} +: 8];
        ld_h   = mem_data_i[{addr_q[1], 4'b0000} +: 16];
        ld_ext = mem_data_i;
        unique case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
            2'b01:   ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
            default: ld_ext = mem_data_i;
        endcase
    end

    // Store word: merge new lane into captured word
    always_comb begin
        st_word = word_q;
        unique case (size_q)
            2'b00:   st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: st_word = wdata_q;
        endcase
    end

    // Outputs decoded from state so reset drops them at once
    always_comb begin
        ready_o     = 1'b0;
        done_o      = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        unique case (state_q)
            IDLE: ready_o = 1'b1;
            RD: begin
                mem_read_o = 1'b1;
                mem_addr_o = {addr_q[31:2], 2'b00};
            end
            WR: begin
                mem_write_o = 1'b1;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_data_o  = st_word;
            end
            DONE: done_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: memory model, reference model, per-cycle compare.
// Honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_data_i;

    load_store_unit dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .misalign_o (misalign_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .mem_data_i (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] mem     [0:63] = '{default: 32'h0};
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};

    assign mem_data_i = mem[mem_addr_o[7:2]];

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (mem_write_o) mem[mem_addr_o[7:2]] <= mem_data_o;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int boff(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'b00) return int'(a);
        if (sz == 2'b01) return 2 * int'(a[1]);
        return 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w,
        input logic [1:0] sz, input logic un, input logic [1:0] a);
        int nb, off;
        logic [63:0] m, v;
        nb = nbytes(sz);
        off = boff(sz, a);
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = ({32'd0, w} >> (8 * off)) & m;
        if (!un && v[8 * nb - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] w,
        input logic [31:0] d, input logic [1:0] sz, input logic [1:0] a);
        int nb, off;
        logic [63:0] mk, r;
        nb = nbytes(sz);
        off = boff(sz, a);
        mk = ((64'd1 << (8 * nb)) - 64'd1) << (8 * off);
        r = ({32'd0, w} & ~mk) | (({32'd0, d} << (8 * off)) & mk);
        return r[31:0];
    endfunction

    // Reference model: schedule of one operation in flight
    logic        m_busy = 1'b0;
    logic        m_is_load, m_mis;
    int          m_rd_cyc, m_wr_cyc, m_done_cyc;
    logic [31:0] m_ld_val, m_wr_word, m_wr_addr;
    logic [31:0] m_rdata = 32'h0;

    task automatic model_accept();
        logic [31:0] w;
        logic        mis;
        w = ref_mem[addr_i[7:2]];
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (size_i == 2'b01 && addr_i[0]) ||
              (size_i[1] && addr_i[1:0] != 2'b00);
`endif
        m_busy = 1'b1;
        m_rd_cyc = -1;
        m_wr_cyc = -1;
        m_is_load = 1'b0;
        m_mis = mis;
        m_wr_addr = {addr_i[31:2], 2'b00};
        if (mis) begin
            m_done_cyc = cyc + 1;
        end else if (!we_i) begin
            m_is_load = 1'b1;
            m_rd_cyc = cyc + 1;
            m_done_cyc = cyc + 2;
            m_ld_val = load_val(w, size_i, unsigned_i, addr_i[1:0]);
        end else if (size_i[1]) begin
            m_wr_cyc = cyc + 1;
            m_done_cyc = cyc + 2;
            m_wr_word = wdata_i;
        end else begin
            m_rd_cyc = cyc + 1;
            m_wr_cyc = cyc + 2;
            m_done_cyc = cyc + 3;
            m_wr_word = store_val(w, wdata_i, size_i, addr_i[1:0]);
        end
    endtask

    // Compare process, mid-cycle
    always @(negedge clk_i) begin
        logic idle_now, e_done, e_rd, e_wr;
        if (!rst_i) begin
            m_busy = 1'b0;
            m_rdata = 32'h0;
        end else begin
            idle_now = !m_busy;
            e_done = m_busy && cyc == m_done_cyc;
            e_rd = m_busy && cyc == m_rd_cyc;
            e_wr = m_busy && cyc == m_wr_cyc;
            if (e_done && m_is_load) m_rdata = m_ld_val;
            chk("ready", {31'd0, ready_o}, {31'd0, idle_now});
            chk("done", {31'd0, done_o}, {31'd0, e_done});
            chk("misalign", {31'd0, misalign_o}, {31'd0, e_done & m_mis});
            chk("mem_read", {31'd0, mem_read_o}, {31'd0, e_rd});
            chk("mem_write", {31'd0, mem_write_o}, {31'd0, e_wr});
            chk("mem_addr", mem_addr_o, (e_rd || e_wr) ? m_wr_addr : 32'h0);
            chk("mem_data", mem_data_o, e_wr ? m_wr_word : 32'h0);
            chk("rdata", rdata_o, m_rdata);
            if (e_wr) ref_mem[m_wr_addr[7:2]] = m_wr_word;
            if (e_done) m_busy = 1'b0;
            if (idle_now && req_i) model_accept();
        end
    end

    task automatic do_op(input logic we, input logic [1:0] sz,
        input logic un, input logic [31:0] a, input logic [31:0] d,
        output int lat, output logic mis);
        int k;
        k = 0;
        while (!ready_o && k < 20) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        we_i = we;
        size_i = sz;
        unsigned_i = un;
        addr_i = a;
        wdata_i = d;
        req_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        we_i = ~we;
        addr_i = 32'hFFFF_FFFF;
        wdata_i = ~d;
        size_i = ~sz;
        lat = 1;
        while (!done_o && lat < 10) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        if (!done_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL op_timeout: got no done_o expected done_o");
        end
        mis = misalign_o;
    endtask

    task automatic set_stream_op(input int j);
        we_i = (j % 2 == 0);
        size_i = 2'b10;
        unsigned_i = 1'b0;
        addr_i = 32'h40 + 32'(4 * (j / 2));
        wdata_i = 32'hA500_0000 + 32'(j);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic mis;
        int dn;
        int k;
        rst_i = 1'b0;
        req_i = 1'b0;
        we_i = 1'b0;
        size_i = 2'b00;
        unsigned_i = 1'b0;
        addr_i = 32'h0;
        wdata_i = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_write_o}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_read_o}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, mis);
        chk("sw_lat", 32'(lat), 32'd2);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, mis);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("mem_10", mem[4], 32'hDEAD_BEEF);

        do_op(1'b1, 2'b11, 1'b0, 32'h20, 32'h1122_3344, lat, mis);
        do_op(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, lat, mis);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("mem_20", mem[8], 32'h11AA_3344);
        do_op(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, lat, mis);
        chk("lb_rdata", rdata_o, 32'hFFFF_FFAA);
        do_op(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, lat, mis);
        chk("lbu_rdata", rdata_o, 32'h0000_00AA);
        do_op(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, lat, mis);
        chk("lb3_rdata", rdata_o, 32'h0000_0011);

        do_op(1'b1, 2'b01, 1'b0, 32'h26, 32'h0000_8001, lat, mis);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("mem_24", mem[9], 32'h8001_0000);
        do_op(1'b0, 2'b01, 1'b0, 32'h26, 32'h0, lat, mis);
        chk("lh_rdata", rdata_o, 32'hFFFF_8001);

        // Reset during WR of a byte store
        k = 0;
        while (!ready_o && k < 20) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        we_i = 1'b1;
        size_i = 2'b00;
        unsigned_i = 1'b0;
        addr_i = 32'h20;
        wdata_i = 32'h55;
        req_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("wr_before_rst", {31'd0, mem_write_o}, 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("wr_fall_rst", {31'd0, mem_write_o}, 32'd0);
        chk("ready_in_rst", {31'd0, ready_o}, 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        chk("mem_20_kept", mem[8], 32'h11AA_3344);
        @(posedge clk_i);
        #1;
        chk("ready_after_rst", {31'd0, ready_o}, 32'd1);
        chk("rdata_after_rst", rdata_o, 32'h0);

        do_op(1'b0, 2'b01, 1'b1, 32'h26, 32'h0, lat, mis);
        chk("lhu_rdata", rdata_o, 32'h0000_8001);
        do_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, mis);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("trap_lat", 32'(lat), 32'd1);
        chk("trap_mis", {31'd0, mis}, 32'd1);
        chk("trap_rdata", rdata_o, 32'h0000_8001);
`else
        chk("mis_lat", 32'(lat), 32'd2);
        chk("mis_flag", {31'd0, mis}, 32'd0);
        chk("mis_rdata", rdata_o, 32'hDEAD_BEEF);
`endif

        // req_i held high across alternating stores and loads
        k = 0;
        while (!ready_o && k < 20) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        dn = 0;
        set_stream_op(0);
        req_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                dn++;
                set_stream_op(dn);
            end
        end
        req_i = 1'b0;
        chk("stream_dones", 32'(dn), 32'd10);
        chk("stream_rdata", rdata_o, 32'hA500_0008);
        chk("mem_50", mem[20], 32'hA500_0008);

        repeat (4) @(posedge clk_i);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
